product_bcd_display: RTL and testbench

- Downstream consumer of the 4-bit multiplier's 8-bit product `P`.
- On a `load` strobe it captures `P` and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) sequence, one bit per clock.
- It then holds the result and drives a 3-digit, time-multiplexed, active-low seven-segment display with leading-zero blanking.

---
 rtl/product_bcd_display_if.sv | 14 +
 rtl/product_bcd_display.sv | 136 +++++++++++++
 tb/tb_product_bcd_display.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/product_bcd_display_if.sv
// Product-to-display bundle: 8-bit product and load strobe in, BCD result, status and display drive out.
// The master modport is the producer side (multiplier or bench); the slave modport is the converter.
interface product_bcd_display_if;
    logic [7:0]  P;
    logic        load;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    modport master (output P, output load, input busy, input done, input bcd, input an, input seg);
    modport slave  (input P, input load, output busy, output done, output bcd, output an, output seg);
endinterface

// File: rtl/product_bcd_display.sv
// Binary product to 3-digit BCD (double-dabble, 8 cycles load-to-done), then a muxed 7-seg display with leading-zero blanking.
// Loads arriving mid-conversion are dropped; a load in the DONE cycle starts the next conversion back-to-back.
module product_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    product_bcd_display_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_bin;
    logic [11:0]     r_scr;
    logic [2:0]      r_step;
    logic [11:0]     r_bcd;
    logic [CW-1:0]   r_ref;
    logic [1:0]      r_sel;

    logic            w_accept;
    logic [11:0]     w_adj;
    logic [11:0]     w_scr_next;
    logic            w_busy;
    logic            w_done;
    logic [3:0]      w_digit;
    logic            w_blank;
    logic [2:0]      w_an;

    assign w_accept = bus.load && (r_state != S_CONV);

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < 3; i++) begin
            if (r_scr[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_scr[i*4 +: 4] + 4'd3;
        end
        w_scr_next = {w_adj[10:0], r_bin[7]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.load) w_next = S_CONV;
            S_CONV:  if (r_step == 3'd7) w_next = S_DONE;
            S_DONE:  w_next = bus.load ? S_CONV : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_CONV);
        w_done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= 8'd0;
            r_scr  <= 12'd0;
            r_step <= 3'd0;
            r_bcd  <= 12'd0;
        end else if (w_accept) begin
            r_bin  <= bus.P;
            r_scr  <= 12'd0;
            r_step <= 3'd0;
        end else if (r_state == S_CONV) begin
            r_bin  <= {r_bin[6:0], 1'b0};
            r_scr  <= w_scr_next;
            r_step <= r_step + 3'd1;
            if (r_step == 3'd7)
                r_bcd <= w_scr_next;
        end
    end

    // Free-running digit mux, independent of the converter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
            r_sel <= 2'd0;
        end else if (r_ref == CW'(REFRESH_DIV - 1)) begin
            r_ref <= '0;
            r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        w_an    = 3'b110;
        case (r_sel)
            2'd1: begin
                w_digit = r_bcd[7:4];
                w_blank = (r_bcd[11:4] == 8'd0);
                w_an    = 3'b101;
            end
            2'd2: begin
                w_digit = r_bcd[11:8];
                w_blank = (r_bcd[11:8] == 4'd0);
                w_an    = 3'b011;
            end
            default: ;
        endcase
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.bcd  = r_bcd;
    assign bus.an   = w_an;
    assign bus.seg  = w_blank ? 7'b1111111 : f_seg(w_digit);
endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display: conversion table, display mux, blanking, load handshake and mid-conversion reset.
module tb_product_bcd_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    product_bcd_display_if bus();

    product_bcd_display #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  p;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int cnt);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            cnt = i;
            if (bus.done) break;
        end
    endtask

    task automatic do_conv(input string name, input logic [7:0] p, input logic [11:0] exp);
        int cnt;
        bus.P    = p;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.P    = 8'hAA;
        check({name, " busy"}, 16'(bus.busy), 16'd1);
        wait_done(cnt);
        check({name, " latency"}, 16'(cnt), 16'd8);
        check({name, " bcd"}, 16'(bus.bcd), 16'(exp));
        step();
        check({name, " done pulse"}, 16'(bus.done), 16'd0);
    endtask

    // Aligns to the first cycle of select 0, then checks 3 slots x 4 cycles.
    task automatic check_display(input string name, input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
        logic [2:0] prev;
        logic [2:0] an_exp [3];
        logic [6:0] seg_exp[3];
        an_exp  = '{3'b110, 3'b101, 3'b011};
        seg_exp = '{s0, s1, s2};
        prev = bus.an;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.an == 3'b110 && prev == 3'b011) break;
            prev = bus.an;
        end
        for (int k = 0; k < 12; k++) begin
            check($sformatf("%s an[%0d]", name, k), 16'(bus.an), 16'(an_exp[k/4]));
            check($sformatf("%s seg[%0d]", name, k), 16'(bus.seg), 16'(seg_exp[k/4]));
            step();
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{8'd9,   12'h009};
        vecs[1] = '{8'd7,   12'h007};
        vecs[2] = '{8'd100, 12'h100};
        vecs[3] = '{8'd225, 12'h225};
        vecs[4] = '{8'd255, 12'h255};

        bus.P    = 8'd0;
        bus.load = 1'b0;
        rst      = 1'b1;
        repeat (3) step();
        check("reset bcd",  16'(bus.bcd),  16'h000);
        check("reset an",   16'(bus.an),   16'(3'b110));
        check("reset seg",  16'(bus.seg),  16'(7'b1000000));
        check("reset busy", 16'(bus.busy), 16'd0);
        check("reset done", 16'(bus.done), 16'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i])
            do_conv($sformatf("conv P=%0d", vecs[i].p), vecs[i].p, vecs[i].exp_bcd);

        do_conv("conv P=100 disp", 8'd100, 12'h100);
        check_display("disp 100", 7'b1000000, 7'b1000000, 7'b1111001);

        do_conv("conv P=7 blank", 8'd7, 12'h007);
        check_display("blank 7", 7'b1111000, 7'b1111111, 7'b1111111);

        // Load at step 4 must be ignored.
        bus.P    = 8'd50;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 4) begin
                bus.P    = 8'd200;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            step();
            cnt = i;
            if (bus.done) break;
        end
        bus.load = 1'b0;
        check("ignore latency", 16'(cnt), 16'd8);
        check("ignore bcd", 16'(bus.bcd), 16'h050);

        // Load held during DONE is accepted back-to-back.
        bus.P    = 8'd200;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        check("b2b busy", 16'(bus.busy), 16'd1);
        check("b2b done low", 16'(bus.done), 16'd0);
        wait_done(cnt);
        check("b2b latency", 16'(cnt), 16'd8);
        check("b2b bcd", 16'(bus.bcd), 16'h200);
        step();

        // Reset at step 5 of a conversion.
        bus.P    = 8'd255;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (5) step();
        check("pre-reset busy", 16'(bus.busy), 16'd1);
        rst = 1'b1;
        #1;
        check("midreset bcd",  16'(bus.bcd),  16'h000);
        check("midreset busy", 16'(bus.busy), 16'd0);
        step();
        rst = 1'b0;
        do_conv("after reset P=64", 8'd64, 12'h064);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
